// File: rtl/botao_debounce_pkg.sv
// botao_debounce_pkg
// Shared definitions for the Mastermind push-button conditioner.
//   estado_t          : debounce FSM states with their fixed 2-bit encoding
//   STATE_W           : width of the state register
//   largura_contador  : counter width able to hold 0..n-1, never below 1 bit
package botao_debounce_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SOLTO       = 2'b00,
        CONF_PRESS  = 2'b01,
        PRESSIONADO = 2'b10,
        CONF_SOLTA  = 2'b11
    } estado_t;

    // $clog2(1) is 0, so a one-cycle counter still needs a single bit
    function automatic int largura_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/botao_debounce_sincronizador_2ff.sv
// sincronizador_2ff
// Two-flop synchronizer for any asynchronous board input.
//   CLK   in  system clock, rising edge
//   RST_n in  asynchronous active-low reset, clears both flops
//   d     in  asynchronous input level
//   q     out level synchronized to CLK, two edges of latency
module sincronizador_2ff (
    input  logic CLK,
    input  logic RST_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/botao_debounce.sv
// botao_debounce
// Turns the raw Mastermind push-button into clean clock-synchronous events.
//   CLK         in  system clock, rising edge
//   RST_n       in  asynchronous active-low reset
//   botao       in  raw button level, 1 = pressed
//   botao_limpo out debounced level (registered)
//   pulso       out one-cycle strobe per accepted press (registered)
//   pulso_longo out one-cycle strobe once per press held LONG_CYCLES (registered)
module botao_debounce
    import botao_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic botao,
    output logic botao_limpo,
    output logic pulso,
    output logic pulso_longo
);

    localparam int CNT_W   = largura_contador(DEBOUNCE_CYCLES);
    localparam int CNT_L_W = largura_contador(LONG_CYCLES);

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_L_W-1:0] CNT_L_MAX = CNT_L_W'(LONG_CYCLES - 1);

    logic w_botao_sync;

    estado_t              r_estado, w_estado_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [CNT_L_W-1:0]   r_cnt_longo, w_cnt_longo_next;
    logic                 r_longo_feito, w_longo_feito_next;
    logic                 r_limpo, w_limpo_next;
    logic                 r_pulso, w_pulso_next;
    logic                 r_pulso_longo, w_pulso_longo_next;

    sincronizador_2ff u_sync (
        .CLK   (CLK),
        .RST_n (RST_n),
        .d     (botao),
        .q     (w_botao_sync)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_estado      <= SOLTO;
            r_cnt         <= '0;
            r_cnt_longo   <= '0;
            r_longo_feito <= 1'b0;
            r_limpo       <= 1'b0;
            r_pulso       <= 1'b0;
            r_pulso_longo <= 1'b0;
        end else begin
            r_estado      <= w_estado_next;
            r_cnt         <= w_cnt_next;
            r_cnt_longo   <= w_cnt_longo_next;
            r_longo_feito <= w_longo_feito_next;
            r_limpo       <= w_limpo_next;
            r_pulso       <= w_pulso_next;
            r_pulso_longo <= w_pulso_longo_next;
        end
    end

    always_comb begin
        w_estado_next      = r_estado;
        w_cnt_next         = r_cnt;
        w_cnt_longo_next   = r_cnt_longo;
        w_longo_feito_next = r_longo_feito;
        w_pulso_next       = 1'b0;
        w_pulso_longo_next = 1'b0;

        case (r_estado)
            SOLTO: begin
                if (w_botao_sync) begin
                    w_estado_next = CONF_PRESS;
                    w_cnt_next    = '0;
                end
            end

            CONF_PRESS: begin
                if (!w_botao_sync) begin
                    w_estado_next = SOLTO;
                    w_cnt_next    = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_estado_next      = PRESSIONADO;
                    w_cnt_next         = '0;
                    w_pulso_next       = 1'b1;
                    w_cnt_longo_next   = '0;
                    w_longo_feito_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            PRESSIONADO: begin
                // Hold time accumulates on every cycle spent here, including the
                // one that leaves; stopping at CNT_L_MAX keeps it from wrapping
                if (!r_longo_feito) begin
                    if (r_cnt_longo == CNT_L_MAX) begin
                        w_pulso_longo_next = 1'b1;
                        w_longo_feito_next = 1'b1;
                    end else begin
                        w_cnt_longo_next = r_cnt_longo + CNT_L_W'(1);
                    end
                end
                if (!w_botao_sync) begin
                    w_estado_next = CONF_SOLTA;
                    w_cnt_next    = '0;
                end
            end

            CONF_SOLTA: begin
                // Release bounce returns to PRESSIONADO without a new pulso and
                // with the hold time preserved
                if (w_botao_sync) begin
                    w_estado_next = PRESSIONADO;
                    w_cnt_next    = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_estado_next = SOLTO;
                    w_cnt_next    = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_estado_next = SOLTO;
                w_cnt_next    = '0;
            end
        endcase

        w_limpo_next = (w_estado_next == PRESSIONADO) || (w_estado_next == CONF_SOLTA);
    end

    assign botao_limpo = r_limpo;
    assign pulso       = r_pulso;
    assign pulso_longo = r_pulso_longo;

endmodule

// File: tb/tb_botao_debounce.sv
// tb_botao_debounce
// Self-checking bench for botao_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// A behavioural model tracks the button as "released/pressed" plus the length
// of the current run of samples that disagree with that level.
module tb_botao_debounce;

    localparam int D = 4;
    localparam int L = 16;

    logic CLK = 1'b0;
    logic RST_n;
    logic botao;
    logic botao_limpo;
    logic pulso;
    logic pulso_longo;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit modelQueue[$];
    bit mPressed;
    int mRun;
    int mHeld;
    bit mLongDone;
    bit ePulso;
    bit eLongo;
    bit eLimpo;

    // Trace of observed events since the last clearTrace
    int edgeIdx;
    int firstPulseEdge;
    int longEdge;
    int pulseCount;
    int longCount;

    botao_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .botao       (botao),
        .botao_limpo (botao_limpo),
        .pulso       (pulso),
        .pulso_longo (pulso_longo)
    );

    always #5 CLK = ~CLK;

    task automatic modelReset();
        modelQueue = {1'b0, 1'b0};
        mPressed   = 1'b0;
        mRun       = 0;
        mHeld      = 0;
        mLongDone  = 1'b0;
        ePulso     = 1'b0;
        eLongo     = 1'b0;
        eLimpo     = 1'b0;
    endtask

    task automatic clearTrace();
        edgeIdx        = 0;
        firstPulseEdge = -1;
        longEdge       = -1;
        pulseCount     = 0;
        longCount      = 0;
    endtask

    // One clock edge of the model: the FSM sees botao from two edges earlier.
    // A level change is accepted after D+1 consecutive agreeing samples; hold
    // time grows on each edge where the button was still seen down.
    task automatic modelEdge(input bit b);
        bit s;
        s = modelQueue.pop_front();
        modelQueue.push_back(b);
        ePulso = 1'b0;
        eLongo = 1'b0;
        if (!mPressed) begin
            if (s) begin
                mRun++;
                if (mRun == D + 1) begin
                    mPressed  = 1'b1;
                    ePulso    = 1'b1;
                    mRun      = 0;
                    mHeld     = 0;
                    mLongDone = 1'b0;
                end
            end else begin
                mRun = 0;
            end
        end else if (mRun == 0) begin
            if (!mLongDone) begin
                mHeld++;
                if (mHeld == L) begin
                    eLongo    = 1'b1;
                    mLongDone = 1'b1;
                end
            end
            if (!s) mRun = 1;
        end else begin
            if (s) begin
                mRun = 0;
            end else begin
                mRun++;
                if (mRun == D + 1) begin
                    mPressed = 1'b0;
                    mRun     = 0;
                end
            end
        end
        eLimpo = mPressed;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b (edge %0d)", tag, observed, expected, edgeIdx);
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, ".pulso"}, pulso, ePulso);
        checkBit({tag, ".pulso_longo"}, pulso_longo, eLongo);
        checkBit({tag, ".botao_limpo"}, botao_limpo, eLimpo);
    endtask

    // Drive one cycle of botao, advance the model on the edge, then compare
    task automatic applyStimulus(input bit b, input string tag);
        botao = b;
        @(posedge CLK);
        modelEdge(b);
        edgeIdx++;
        #1;
        if (pulso === 1'b1) begin
            pulseCount++;
            if (firstPulseEdge < 0) firstPulseEdge = edgeIdx;
        end
        if (pulso_longo === 1'b1) begin
            longCount++;
            longEdge = edgeIdx;
        end
        checkOutput(tag);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock
    task automatic doReset(input string tag);
        RST_n = 1'b0;
        #2;
        modelReset();
        checkOutput(tag);
        @(negedge CLK);
        RST_n = 1'b1;
        clearTrace();
    endtask

    initial begin
        RST_n = 1'b1;
        botao = 1'b0;
        modelReset();
        clearTrace();
        @(negedge CLK);
        doReset("reset");

        // Clean press of 12 cycles then release
        repeat (12) applyStimulus(1'b1, "press12");
        checkInt("press12.firstPulseEdge", firstPulseEdge, D + 3);
        repeat (12) applyStimulus(1'b0, "release12");
        checkInt("press12.pulseCount", pulseCount, 1);

        // Two-cycle glitch is rejected
        clearTrace();
        repeat (2) applyStimulus(1'b1, "glitch");
        repeat (10) applyStimulus(1'b0, "glitch");
        checkInt("glitch.pulseCount", pulseCount, 0);

        // Long hold: one long pulse
        clearTrace();
        repeat (40) applyStimulus(1'b1, "hold40");
        checkInt("hold40.longEdge", longEdge, D + 3 + L);
        checkInt("hold40.longCount", longCount, 1);
        repeat (12) applyStimulus(1'b0, "hold40rel");

        // Release bounce while pressed freezes the hold count for one cycle
        clearTrace();
        repeat (10) applyStimulus(1'b1, "bounce");
        applyStimulus(1'b0, "bounce");
        repeat (29) applyStimulus(1'b1, "bounce");
        checkInt("bounce.pulseCount", pulseCount, 1);
        checkInt("bounce.longEdge", longEdge, D + 3 + L + 1);
        repeat (12) applyStimulus(1'b0, "bounceRel");

        // Reset during a press with botao held: counts as a fresh press
        clearTrace();
        repeat (6) applyStimulus(1'b1, "midReset");
        doReset("midReset.rst");
        repeat (12) applyStimulus(1'b1, "afterReset");
        checkInt("afterReset.firstPulseEdge", firstPulseEdge, D + 3);
        checkInt("afterReset.pulseCount", pulseCount, 1);

        // Reset while fully pressed: botao_limpo must drop immediately
        doReset("pressedReset");
        repeat (10) applyStimulus(1'b0, "pressedResetRel");

        // Randomized runs of high/low of varied lengths
        for (int seg = 0; seg < 150; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) len = $urandom_range(20, 30);
            else len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) applyStimulus(lvl, "random");
            if ($urandom_range(0, 60) == 0) doReset("randomReset");
        end

        $display("[TB] directed and random sequences complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
